dmux_4way: RTL and testbench
============================

DMUX_4WAY -- requirements
Module: dmux_4way

Interface
REQ-001 Parameter WIDTH, default 1, data width of in and each output channel.
REQ-002 Parameter CNT_W, default 8, width of each per-channel routing counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in  input  WIDTH  data word to route.
REQ-006 sel  input  2  channel select: 00->a, 01->b, 10->c, 11->d.
REQ-007 in_valid  input  1  qualifies in/sel for the current cycle.
REQ-008 cnt_clr  input  1  synchronous clear of all routing counters.
REQ-009 a, b, c, d  output  WIDTH each  registered demultiplexed outputs.
REQ-010 out_valid  output  4  registered one-hot channel-valid flags; bit0=a, bit1=b, bit2=c, bit3=d.
REQ-011 cnt_a, cnt_b, cnt_c, cnt_d  output  CNT_W each  count of accepted words routed to each channel.

Function
REQ-012 The outputs SHALL register the 4-way demux of in on each rising clk edge (1-cycle latency).
REQ-013 With in_valid=1, the channel selected by sel SHALL take the value of in, and the other three channels SHALL be all-zero.
REQ-014 With in_valid=1, out_valid SHALL take the one-hot code of sel (00->0001, 01->0010, 10->0100, 11->1000).
REQ-015 With in_valid=0, a, b, c and d SHALL all load zero, and out_valid SHALL load 0000.
REQ-016 Bitwise, for every bit i: selected_channel[i] = in[i] AND in_valid, and every non-selected channel bit is 0.
REQ-017 When in_valid=1 and in is all-zero, all data outputs SHALL be zero, but out_valid SHALL still flag the selected channel.
REQ-018 Each edge with in_valid=1 SHALL increment the counter of the selected channel by 1; the other counters SHALL hold.
REQ-019 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-020 When cnt_clr=1, all counters SHALL load zero on that edge.
REQ-021 cnt_clr SHALL take priority over a simultaneous increment.
REQ-022 cnt_clr SHALL NOT affect the data outputs or out_valid.
REQ-023 sel and in are sampled only at the clock edge; changes between edges SHALL have no effect on the outputs.
REQ-024 There SHALL be no combinational path from any input to any output.

Reset
REQ-025 reset=1 SHALL immediately, independent of clk, force a, b, c, d, out_valid and all counters to zero.
REQ-026 While reset=1, all outputs SHALL hold zero regardless of in_valid or cnt_clr.
REQ-027 The first capture after reset deassertion SHALL occur on the first rising clk edge at which reset=0.
REQ-028 Reset asserted mid-stream SHALL discard any pending word, with no partial update.

Verification
REQ-029 WIDTH=1, in=0, in_valid=1, sel stepped 00,01,10,11 -> a=b=c=d=0 each cycle; out_valid 0001,0010,0100,1000.
REQ-030 WIDTH=1, in=1, in_valid=1, sel stepped 00,01,10,11 -> one cycle later a=1, then b=1, then c=1, then d=1, with the other three 0 each time.
REQ-031 WIDTH=8, in=8'hA5, sel=10, in_valid toggled 1 then 0 -> c=A5 with a=b=d=00, then all four channels 00 and out_valid=0000.
REQ-032 CNT_W=2, sel=11, 5 accepted words -> cnt_d=3 (saturated); then cnt_clr=1 together with in_valid=1 -> all counters 0.
REQ-033 Reset asserted asynchronously between edges while d=1 -> all outputs 0 before the next clk edge; after release, sel=01 with in=1 -> b=1 one cycle later.

Source files
------------

// File: rtl/dmux_4way.sv
// dmux_4way: registered 1-to-4 demultiplexer with per-channel valid flags
// and saturating counters of the words routed to each channel.
module dmux_4way #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       sel,
  input  logic             in_valid,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [3:0]       out_valid,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic [CNT_W-1:0] cnt_c,
  output logic [CNT_W-1:0] cnt_d
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [3:0]       valid_nxt;
  logic [WIDTH-1:0] data_nxt [4];
  logic [WIDTH-1:0] data_q   [4];
  logic [CNT_W-1:0] cnt_nxt  [4];
  logic [CNT_W-1:0] cnt_q    [4];

  // Decode the select into a one-hot flag, steer data, and compute the next
  // counter values (clear wins over increment; increment stops at all-ones).
  always_comb begin
    valid_nxt = 4'b0000;
    if (in_valid) begin
      valid_nxt[sel] = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      data_nxt[i] = valid_nxt[i] ? in : '0;
      cnt_nxt[i]  = cnt_q[i];
      if (cnt_clr) begin
        cnt_nxt[i] = '0;
      end else if (valid_nxt[i] && (cnt_q[i] != CNT_MAX)) begin
        cnt_nxt[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Output and counter registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      out_valid <= valid_nxt;
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= data_nxt[i];
        cnt_q[i]  <= cnt_nxt[i];
      end
    end
  end

  assign a     = data_q[0];
  assign b     = data_q[1];
  assign c     = data_q[2];
  assign d     = data_q[3];
  assign cnt_a = cnt_q[0];
  assign cnt_b = cnt_q[1];
  assign cnt_c = cnt_q[2];
  assign cnt_d = cnt_q[3];

endmodule

// File: tb/tb_dmux_4way.sv
// Bench for dmux_4way: an 8-bit/2-bit-counter instance and a 1-bit/8-bit-counter
// instance share stimulus and are checked against a behavioural model.
module tb_dmux_4way;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in8;
  logic [1:0] sel;
  logic       in_valid;
  logic       cnt_clr;

  logic [7:0] a8, b8, c8, d8;
  logic [3:0] ov8;
  logic [1:0] ca8, cb8, cc8, cd8;
  logic       a1, b1, c1, d1;
  logic [3:0] ov1;
  logic [7:0] ca1, cb1, cc1, cd1;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_data [4];
  logic [3:0] m_valid;
  int         m_cnt2 [4];
  int         m_cnt8 [4];

  always #5 clk = ~clk;

  dmux_4way #(.WIDTH(8), .CNT_W(2)) dut8 (
    .clk(clk), .reset(reset), .in(in8), .sel(sel), .in_valid(in_valid),
    .cnt_clr(cnt_clr), .a(a8), .b(b8), .c(c8), .d(d8), .out_valid(ov8),
    .cnt_a(ca8), .cnt_b(cb8), .cnt_c(cc8), .cnt_d(cd8)
  );

  dmux_4way #(.WIDTH(1), .CNT_W(8)) dut1 (
    .clk(clk), .reset(reset), .in(in8[0]), .sel(sel), .in_valid(in_valid),
    .cnt_clr(cnt_clr), .a(a1), .b(b1), .c(c1), .d(d1), .out_valid(ov1),
    .cnt_a(ca1), .cnt_b(cb1), .cnt_c(cc1), .cnt_d(cd1)
  );

  logic [83:0] obs;
  assign obs = {ov8, a8, b8, c8, d8, ca8, cb8, cc8, cd8,
                ov1, a1, b1, c1, d1, ca1, cb1, cc1, cd1};

  function automatic logic [83:0] model_vec();
    logic [7:0] d0, d1v, d2, d3;
    d0 = m_data[0]; d1v = m_data[1]; d2 = m_data[2]; d3 = m_data[3];
    return {m_valid, d0, d1v, d2, d3,
            2'(m_cnt2[0]), 2'(m_cnt2[1]), 2'(m_cnt2[2]), 2'(m_cnt2[3]),
            m_valid, d0[0], d1v[0], d2[0], d3[0],
            8'(m_cnt8[0]), 8'(m_cnt8[1]), 8'(m_cnt8[2]), 8'(m_cnt8[3])};
  endfunction

  function automatic void model_clear();
    m_valid = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      m_data[i] = 8'h00;
      m_cnt2[i] = 0;
      m_cnt8[i] = 0;
    end
  endfunction

  function automatic void model_edge(input logic v, input int s,
                                     input logic [7:0] din, input logic clr);
    m_valid = v ? 4'(1 << s) : 4'b0000;
    for (int i = 0; i < 4; i++) begin
      m_data[i] = (v && i == s) ? din : 8'h00;
      if (clr) begin
        m_cnt2[i] = 0;
        m_cnt8[i] = 0;
      end else if (v && i == s) begin
        m_cnt2[i] = (m_cnt2[i] + 1 > 3)   ? 3   : m_cnt2[i] + 1;
        m_cnt8[i] = (m_cnt8[i] + 1 > 255) ? 255 : m_cnt8[i] + 1;
      end
    end
  endfunction

  // Advance one clock and move the model by what was on the inputs at that edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (reset) model_clear();
    else model_edge(in_valid, int'(sel), in8, cnt_clr);
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (obs !== 84'h0) begin
      bad++;
      $display("FAIL reset_initial: got %h want %h", obs, 84'h0);
    end
    for (int k = 0; k < 4; k++) begin
      in8 = 8'($urandom); sel = 2'(k); in_valid = 1'b1; cnt_clr = 1'(k & 1);
      step();
      total++;
      if (obs !== 84'h0) begin
        bad++;
        $display("FAIL reset_hold: got %h want %h", obs, 84'h0);
      end
    end
    reset = 1'b0;
    in_valid = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic test_zero_data();
    for (int s = 0; s < 4; s++) begin
      in8 = 8'h00; sel = 2'(s); in_valid = 1'b1; cnt_clr = 1'b0;
      step();
      total++;
      if (obs !== model_vec() || ov8 !== 4'(1 << s) || {a8, b8, c8, d8} !== 32'h0) begin
        bad++;
        $display("FAIL zero_data sel=%0d: got %h want %h", s, obs, model_vec());
      end
    end
  endtask

  task automatic test_route();
    for (int s = 0; s < 4; s++) begin
      in8 = 8'hA5; sel = 2'(s); in_valid = 1'b1;
      step();
      total++;
      if (obs !== model_vec() || {d1, c1, b1, a1} !== 4'(1 << s)) begin
        bad++;
        $display("FAIL route sel=%0d: got %h want %h", s, obs, model_vec());
      end
    end
  endtask

  task automatic test_valid_toggle();
    in8 = 8'hA5; sel = 2'b10; in_valid = 1'b1;
    step();
    total++;
    if (obs !== model_vec() || {a8, b8, c8, d8} !== 32'h0000A500) begin
      bad++;
      $display("FAIL toggle_on: got %h want %h", obs, model_vec());
    end
    in_valid = 1'b0;
    step();
    total++;
    if (obs !== model_vec() || ov8 !== 4'b0000 || {a8, b8, c8, d8} !== 32'h0) begin
      bad++;
      $display("FAIL toggle_off: got %h want %h", obs, model_vec());
    end
  endtask

  task automatic test_saturate();
    cnt_clr = 1'b1; in_valid = 1'b0;
    step();
    cnt_clr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in8 = 8'($urandom); sel = 2'b11; in_valid = 1'b1;
      step();
    end
    total++;
    if (obs !== model_vec() || cd8 !== 2'd3 || cd1 !== 8'd5) begin
      bad++;
      $display("FAIL saturate: got cd8=%0d cd1=%0d want 3 5", cd8, cd1);
    end
    in8 = 8'h3C; cnt_clr = 1'b1; in_valid = 1'b1; sel = 2'b11;
    step();
    total++;
    if (obs !== model_vec() || {ca8, cb8, cc8, cd8} !== 8'h0 ||
        {ca1, cb1, cc1, cd1} !== 32'h0 || d8 !== 8'h3C || ov8 !== 4'b1000) begin
      bad++;
      $display("FAIL clear_priority: got %h want %h", obs, model_vec());
    end
    cnt_clr = 1'b0;
  endtask

  task automatic test_between_edges();
    for (int k = 0; k < 6; k++) begin
      in8 = 8'($urandom); sel = 2'($urandom); in_valid = 1'b1;
      step();
      #2;
      in8 = ~in8; sel = sel + 2'd1; in_valid = 1'($urandom);
      #1;
      total++;
      if (obs !== model_vec()) begin
        bad++;
        $display("FAIL between_edges: got %h want %h", obs, model_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      in8 = 8'($urandom); sel = 2'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      cnt_clr = ($urandom_range(0, 19) == 0);
      step();
      total++;
      if (obs !== model_vec()) begin
        bad++;
        $display("FAIL random k=%0d: got %h want %h", k, obs, model_vec());
      end
    end
    cnt_clr = 1'b0;
  endtask

  task automatic test_async_reset();
    in8 = 8'hFF; sel = 2'b11; in_valid = 1'b1;
    step();
    total++;
    if (obs !== model_vec() || d1 !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset: got %h want %h", obs, model_vec());
    end
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    total++;
    if (obs !== 84'h0) begin
      bad++;
      $display("FAIL async_reset: got %h want %h", obs, 84'h0);
    end
    step();
    reset = 1'b0;
    in8 = 8'h01; sel = 2'b01; in_valid = 1'b1;
    step();
    total++;
    if (obs !== model_vec() || b1 !== 1'b1 || b8 !== 8'h01 || ov8 !== 4'b0010) begin
      bad++;
      $display("FAIL post_reset: got %h want %h", obs, model_vec());
    end
  endtask

  initial begin
    reset = 1'b1; in8 = 8'h00; sel = 2'b00; in_valid = 1'b0; cnt_clr = 1'b0;
    model_clear();
    test_reset();
    test_zero_data();
    test_route();
    test_valid_toggle();
    test_saturate();
    test_between_edges();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
